// File: rtl/popcount_stream_pkg.sv
// Shared types and helpers for the streaming population counter.
// Holds the count mode, the partial-sum width rule and the saturating add.
package popcount_stream_pkg;

  typedef enum logic {
    COUNT_ONES  = 1'b0,
    COUNT_ZEROS = 1'b1
  } mode_t;

  // Widest accumulator the saturating adder supports.
  localparam int unsigned ACC_MAX_W = 64;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int unsigned psum_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Returns {ovf, sum}; sum clamps to 2^acc_width-1 when the true sum exceeds it.
  function automatic logic [ACC_MAX_W:0] sat_add(input logic [ACC_MAX_W-1:0] a,
                                                 input logic [ACC_MAX_W-1:0] b,
                                                 input int unsigned          acc_width);
    logic [ACC_MAX_W:0] lim;
    logic [ACC_MAX_W:0] sum;
    if (acc_width >= ACC_MAX_W) lim = {1'b0, {ACC_MAX_W{1'b1}}};
    else lim = ((ACC_MAX_W+1)'(1) << acc_width) - (ACC_MAX_W+1)'(1);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > lim) return {1'b1, lim[ACC_MAX_W-1:0]};
    return {1'b0, sum[ACC_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/popcount_chunk_pipe.sv
// Chunked popcount pipeline: stage k adds the ones in chunk k-1 to a running
// partial sum, carrying only the still-uncounted upper chunks forward.
module popcount_chunk_pipe
  import popcount_stream_pkg::*;
#(
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned PIPELINE_SIZE = 16,
  parameter int unsigned PSW           = psum_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             en_i,
  input  logic             in_val_i,
  input  logic             in_first_i,
  input  logic             in_last_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_val_o,
  output logic             out_first_o,
  output logic             out_last_o,
  output logic [PSW-1:0]   out_cnt_o
);

  localparam int unsigned PC = WIDTH / PIPELINE_SIZE;

  function automatic logic [PSW-1:0] chunk_count(input logic [PIPELINE_SIZE-1:0] chunk);
    logic [PSW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(PIPELINE_SIZE); i++) n = n + PSW'(chunk[i]);
    return n;
  endfunction

  for (genvar k = 1; k <= int'(PC); k++) begin : g_stage
    localparam int unsigned IN_W = WIDTH - (k - 1) * PIPELINE_SIZE;

    logic [IN_W-1:0] d_in;
    logic [PSW-1:0]  s_in;
    logic            v_in, f_in, l_in;
    logic [PSW-1:0]  psum_q;
    logic            val_q, first_q, last_q;

    if (k == 1) begin : g_head
      assign d_in = in_data_i;
      assign s_in = '0;
      assign v_in = in_val_i;
      assign f_in = in_first_i;
      assign l_in = in_last_i;
    end else begin : g_link
      assign d_in = g_stage[k-1].g_rest.rest_q;
      assign s_in = g_stage[k-1].psum_q;
      assign v_in = g_stage[k-1].val_q;
      assign f_in = g_stage[k-1].first_q;
      assign l_in = g_stage[k-1].last_q;
    end

    // NOTE: sequential state uses <= so every stage samples the previous
    // stage's old value on the same edge, regardless of block order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) val_q <= 1'b0;
      else if (en_i) val_q <= v_in;
    end

    // NOTE: only valid bits are reset; payload is qualified by valid, so
    // leaving it unreset saves reset routing without changing behaviour.
    always_ff @(posedge clk_i) begin
      if (en_i) begin
        psum_q  <= s_in + chunk_count(d_in[PIPELINE_SIZE-1:0]);
        first_q <= f_in;
        last_q  <= l_in;
      end
    end

    if (k < int'(PC)) begin : g_rest
      logic [IN_W-PIPELINE_SIZE-1:0] rest_q;
      always_ff @(posedge clk_i) begin
        if (en_i) rest_q <= d_in[IN_W-1:PIPELINE_SIZE];
      end
    end
  end

  assign out_val_o   = g_stage[PC].val_q;
  assign out_first_o = g_stage[PC].first_q;
  assign out_last_o  = g_stage[PC].last_q;
  assign out_cnt_o   = g_stage[PC].psum_q;

endmodule

// File: rtl/popcount_stream.sv
// Streaming popcount with packet accumulation, count-zeros mode, saturation
// and full backpressure; one result per packet, emitted on its last beat.
module popcount_stream
  import popcount_stream_pkg::*;
#(
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned PIPELINE_SIZE = 16,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 data_val_i,
  input  logic                 data_first_i,
  input  logic                 data_last_i,
  input  logic                 mode_i,
  output logic                 data_ready_o,
  output logic [ACC_WIDTH-1:0] data_o,
  output logic                 ovf_o,
  output logic                 data_val_o,
  input  logic                 data_ready_i
);

  localparam int unsigned PSW = psum_width(WIDTH);

  if (WIDTH % PIPELINE_SIZE != 0) begin : g_bad_width
    $error("popcount_stream: WIDTH must be a multiple of PIPELINE_SIZE");
  end
  if (ACC_WIDTH < PSW || ACC_WIDTH > ACC_MAX_W) begin : g_bad_acc
    $error("popcount_stream: ACC_WIDTH must be in [clog2(WIDTH)+1, 64]");
  end

  // The whole pipeline freezes while a result waits on the consumer.
  logic en;
  assign en           = !(data_val_o && !data_ready_i);
  assign data_ready_o = en;

  mode_t            mode_q, beat_mode;
  logic             s0_val, s0_first, s0_last;
  logic [WIDTH-1:0] s0_data;

  assign beat_mode = data_first_i ? mode_t'(mode_i) : mode_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s0_val <= 1'b0;
      mode_q <= COUNT_ONES;
    end else if (en) begin
      s0_val <= data_val_i;
      if (data_val_i && data_first_i) mode_q <= mode_t'(mode_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      s0_data  <= (beat_mode == COUNT_ZEROS) ? ~data_i : data_i;
      s0_first <= data_first_i;
      s0_last  <= data_last_i;
    end
  end

  logic           p_val, p_first, p_last;
  logic [PSW-1:0] p_cnt;

  popcount_chunk_pipe #(
    .WIDTH         (WIDTH),
    .PIPELINE_SIZE (PIPELINE_SIZE),
    .PSW           (PSW)
  ) u_pipe (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .en_i        (en),
    .in_val_i    (s0_val),
    .in_first_i  (s0_first),
    .in_last_i   (s0_last),
    .in_data_i   (s0_data),
    .out_val_o   (p_val),
    .out_first_o (p_first),
    .out_last_o  (p_last),
    .out_cnt_o   (p_cnt)
  );

  logic [ACC_WIDTH-1:0] acc_q, acc_base, beat_sum, fin_cnt_q;
  logic                 acc_ovf_q, beat_ovf, fin_val_q, fin_ovf_q;
  logic [ACC_MAX_W:0]   sum_ext;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_base = p_first ? '0 : acc_q;
    sum_ext  = sat_add(ACC_MAX_W'(acc_base), ACC_MAX_W'(p_cnt), ACC_WIDTH);
    beat_sum = sum_ext[ACC_WIDTH-1:0];
    beat_ovf = sum_ext[ACC_MAX_W] | (!p_first && acc_ovf_q);
  end

  // Upper sum bits are zero by construction once clamped to ACC_WIDTH.
  if (ACC_WIDTH < ACC_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |sum_ext[ACC_MAX_W-1:ACC_WIDTH];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      fin_val_q  <= 1'b0;
      fin_cnt_q  <= '0;
      fin_ovf_q  <= 1'b0;
      data_val_o <= 1'b0;
      data_o     <= '0;
      ovf_o      <= 1'b0;
    end else if (en) begin
      fin_val_q <= p_val && p_last;
      if (p_val) begin
        if (p_last) begin
          acc_q     <= '0;
          acc_ovf_q <= 1'b0;
          fin_cnt_q <= beat_sum;
          fin_ovf_q <= beat_ovf;
        end else begin
          acc_q     <= beat_sum;
          acc_ovf_q <= beat_ovf;
        end
      end
      data_val_o <= fin_val_q;
      if (fin_val_q) begin
        data_o <= fin_cnt_q;
        ovf_o  <= fin_ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_popcount_stream.sv
// Directed and random bench for popcount_stream with an in-order scoreboard
// fed at beat acceptance and drained at result acceptance.
module tb_popcount_stream;

  localparam int W   = 128;
  localparam int AW  = 32;
  localparam int LAT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n;
  logic [W-1:0]  data;
  logic          data_val, data_first, data_last, mode;
  logic          data_ready;
  logic [AW-1:0] dout;
  logic          ovf, dval;
  logic          rdy_dir, rand_rdy_en, rdy_rand;
  logic          data_ready_in;
  assign data_ready_in = rand_rdy_en ? rdy_rand : rdy_dir;

  logic [W-1:0]  d8;
  logic          v8, f8, l8, mode8, rdy8, ready8;
  logic [7:0]    out8;
  logic          ovf8, val8;

  popcount_stream #(.WIDTH(W), .PIPELINE_SIZE(16), .ACC_WIDTH(AW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data), .data_val_i(data_val),
    .data_first_i(data_first), .data_last_i(data_last), .mode_i(mode),
    .data_ready_o(data_ready), .data_o(dout), .ovf_o(ovf), .data_val_o(dval),
    .data_ready_i(data_ready_in)
  );

  popcount_stream #(.WIDTH(W), .PIPELINE_SIZE(16), .ACC_WIDTH(8)) dut8 (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(d8), .data_val_i(v8),
    .data_first_i(f8), .data_last_i(l8), .mode_i(mode8),
    .data_ready_o(ready8), .data_o(out8), .ovf_o(ovf8), .data_val_o(val8),
    .data_ready_i(rdy8)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] cnt;
    logic          ovf;
    int            edge_n;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_pop;
  int            cyc = 0;
  int            n_out = 0;
  logic [AW-1:0] last_out;
  logic [AW-1:0] m_acc;
  logic          m_ovf, m_mode, m_eff;
  logic [63:0]   m_sum;
  logic          prev_stall;
  logic [AW-1:0] prev_data;
  logic          prev_ovf;
  logic          lat_chk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern for the random phase: 75% ready plus a 20-cycle hold.
  int rcyc = 0;
  always @(posedge clk) begin
    #1;
    rcyc++;
    if ((rcyc % 150) >= 40 && (rcyc % 150) < 60) rdy_rand = 1'b0;
    else rdy_rand = ($urandom_range(0, 3) != 0);
  end

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      m_acc = '0; m_ovf = 1'b0; m_mode = 1'b0;
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_val_held", dval, 1);
        check("stall_data_held", dout, prev_data);
        check("stall_ovf_held", ovf, prev_ovf);
      end
      check("ready_vs_stall", data_ready, !(dval && !data_ready_in));
      if (data_val && data_ready) begin
        m_eff = data_first ? mode : m_mode;
        if (data_first) begin
          m_mode = mode; m_acc = '0; m_ovf = 1'b0;
        end
        m_sum = 64'(m_acc) + 64'($countones(m_eff ? ~data : data));
        if (m_sum > 64'hFFFF_FFFF) begin
          m_acc = '1; m_ovf = 1'b1;
        end else m_acc = m_sum[AW-1:0];
        if (data_last) begin
          sb.push_back('{cnt: m_acc, ovf: m_ovf, edge_n: cyc + 1});
          m_acc = '0; m_ovf = 1'b0;
        end
      end
      if (dval && data_ready_in) begin
        check("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          check("result_data", dout, e_pop.cnt);
          check("result_ovf", ovf, e_pop.ovf);
          if (lat_chk) check("result_latency", cyc - e_pop.edge_n, LAT);
          last_out = dout;
          n_out++;
        end
      end
      prev_stall = dval && !data_ready_in;
      prev_data  = dout;
      prev_ovf   = ovf;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic f, input logic l, input logic m);
    logic ok;
    int   t;
    data = d; data_first = f; data_last = l; mode = m; data_val = 1'b1;
    ok = 1'b0; t = 0;
    while (!ok && t < 200) begin
      @(negedge clk); ok = data_ready;
      @(posedge clk); #1; t++;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    data_val = 1'b0; data_first = 1'b0; data_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk); t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
    check("drain_no_valid", dval, 0);
  endtask

  logic [W-1:0] beat_d;
  logic         beat_f, beat_l, beat_m;
  int           n0;
  int           n8;
  logic [7:0]   r8_d[3];
  logic         r8_o[3];

  initial begin
    arst_n = 1'b0; data = '0; data_val = 1'b0; data_first = 1'b0; data_last = 1'b0;
    mode = 1'b0; rdy_dir = 1'b1; rand_rdy_en = 1'b0; lat_chk = 1'b1;
    d8 = '0; v8 = 1'b0; f8 = 1'b0; l8 = 1'b0; mode8 = 1'b0; rdy8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_val", dval, 0);
    check("reset_data", dout, 0);
    check("reset_ovf", ovf, 0);
    check("reset_ready", data_ready, 1);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-beat packets of 2^i-1.
    n0 = n_out;
    for (int i = 0; i <= W; i++) begin
      beat_d = (i == W) ? '1 : ((128'd1 << i) - 128'd1);
      send(beat_d, 1'b1, 1'b1, 1'b0);
    end
    idle();
    drain();
    check("ones_ramp_count", n_out - n0, W + 1);

    // Count-zeros singles, then a packet whose mode is set on its first beat only.
    n0 = n_out;
    send('0, 1'b1, 1'b1, 1'b1);
    send('1, 1'b1, 1'b1, 1'b1);
    send(128'hF0, 1'b1, 1'b1, 1'b1);
    send(128'hFF, 1'b1, 1'b0, 1'b1);
    send('0, 1'b0, 1'b1, 1'b0);
    idle();
    drain();
    check("zeros_count", n_out - n0, 4);
    check("zeros_latched_mode", last_out, 248);

    // Three-beat packet then a single beat: exactly two results.
    n0 = n_out;
    send('1, 1'b1, 1'b0, 1'b0);
    send('1, 1'b0, 1'b0, 1'b0);
    send('1, 1'b0, 1'b1, 1'b0);
    send(128'h1F, 1'b1, 1'b1, 1'b0);
    idle();
    drain();
    check("multi_beat_count", n_out - n0, 2);
    check("multi_beat_last", last_out, 5);

    // Random stream with gaps and a randomly stalling consumer.
    rand_rdy_en = 1'b1; lat_chk = 1'b0;
    for (int b = 0; b < 200; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(posedge clk); #1;
      end
      beat_d = {$urandom, $urandom, $urandom, $urandom};
      beat_f = ($urandom_range(0, 3) == 0);
      beat_l = ($urandom_range(0, 3) == 0);
      beat_m = 1'($urandom_range(0, 1));
      send(beat_d, beat_f, beat_l, beat_m);
    end
    idle();
    drain();
    rand_rdy_en = 1'b0; lat_chk = 1'b1;

    // Reset with five beats of an open packet in flight.
    send('1, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) send(128'h1, 1'b0, 1'b0, 1'b0);
    idle();
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    check("midreset_val", dval, 0);
    check("midreset_data", dout, 0);
    check("midreset_ovf", ovf, 0);
    check("midreset_ready", data_ready, 1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    n0 = n_out;
    send(128'h1, 1'b0, 1'b0, 1'b1);
    send(128'h3, 1'b0, 1'b1, 1'b1);
    idle();
    drain();
    check("post_reset_count", n_out - n0, 1);
    check("post_reset_result", last_out, 3);

    // Eight-bit accumulator: saturation, recovery, and the exact-limit boundary.
    check("acc8_ready", ready8, 1);
    v8 = 1'b1; d8 = '1; f8 = 1'b1; l8 = 1'b0;
    @(posedge clk); #1; f8 = 1'b0;
    @(posedge clk); #1; l8 = 1'b1;
    @(posedge clk); #1; d8 = 128'h1F; f8 = 1'b1; l8 = 1'b1;
    @(posedge clk); #1; d8 = '1; f8 = 1'b1; l8 = 1'b0;
    @(posedge clk); #1; d8 = {1'b0, {(W-1){1'b1}}}; f8 = 1'b0; l8 = 1'b1;
    @(posedge clk); #1; v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
    n8 = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (val8) begin
        if (n8 < 3) begin
          r8_d[n8] = out8;
          r8_o[n8] = ovf8;
        end
        n8++;
      end
    end
    check("acc8_count", n8, 3);
    check("acc8_sat_data", r8_d[0], 255);
    check("acc8_sat_ovf", r8_o[0], 1);
    check("acc8_after_data", r8_d[1], 5);
    check("acc8_after_ovf", r8_o[1], 0);
    check("acc8_limit_data", r8_d[2], 255);
    check("acc8_limit_ovf", r8_o[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
